pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Generic parametrised pipeline-stage register with valid/ready handshake, stall and flush.
//  Successor to the fixed-field, always-load stage registers. One instance per stage boundary
//  (IF/ID, ID/EX, EX/MEM, MEM/WB). Fields are packed into ctrl (side-effect bits) and data (payload).
//  Flush inserts a bubble. Back-pressure holds the stage contents. A saturating stall counter
//  provides a performance counter.
// PARAMETERS
//  CTRL_W       5    width of ctrl bus (memRead, memWrite, wbEn, branch, s); forced 0 on bubble
//  DATA_W       141  width of payload (pc, aluCmd, Rn, Rm, imm, shiftOp, imm24, dest)
//  STALL_CNT_W  16   width of saturating stall counter
// PORTS
//  clk        in   1            clock, all state on rising edge
//  rst        in   1            synchronous reset, active-high
//  flush      in   1            kill stored entry and any entry presented this cycle
//  in_valid   in   1            upstream entry valid
//  in_ready   out  1            stage can accept (transfer when in_valid & in_ready)
//  in_ctrl    in   CTRL_W       upstream control bits
//  in_data    in   DATA_W       upstream payload
//  out_valid  out  1            stage holds a valid entry
//  out_ready  in   1            downstream accepts (transfer when out_valid & out_ready)
//  out_ctrl   out  CTRL_W       stored ctrl; all-zero whenever out_valid=0
//  out_data   out  DATA_W       stored payload (don't-care when out_valid=0, but deterministic)
//  stall_cnt  out  STALL_CNT_W  cycles with out_valid & !out_ready, saturating
// BEHAVIOUR
//  - Reset (rst=1 at edge): out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, skid empty;
//    in_ready=0 while rst is high. rst has priority over flush and all handshakes.
//  - States: EMPTY (out_valid=0), FULL (out_valid=1), and FULL_SKID (SKID_EN only).
//  - Latency: 1 cycle in_* -> out_*. Throughput: 1 entry/cycle when out_ready=1.
//  - EMPTY: in fire -> FULL, capture in_ctrl/in_data.
//  - FULL with out fire and in fire: reload with new entry, stay FULL.
//  - FULL with out fire only: -> EMPTY, out_ctrl cleared to 0, out_data holds last value.
//  - FULL with out_ready=0: hold all outputs bit-exact (stall).
//  - flush=1 (rst=0): next state EMPTY, out_ctrl=0, skid emptied. An in fire in the same cycle
//    is consumed and discarded (upstream sees a transfer). stall_cnt is not affected by flush.
//  - stall_cnt: +1 on each cycle with out_valid & !out_ready; holds at 2^STALL_CNT_W-1;
//    cleared only by rst.
//  - out_ctrl is gated by the valid register, never by a combinational path from in_*.
// CONFIGURATION
//  SKID_BUF_EN defined:
//    - Adds a 1-entry skid buffer. in_ready is a registered signal, equal to !skid_valid.
//    - In FULL with in fire and no out fire, the entry goes to skid -> FULL_SKID.
//    - FULL_SKID: on out fire, skid moves to output, -> FULL.
//    - No combinational path exists from out_ready to in_ready.
//  SKID_BUF_EN undefined:
//    - No skid buffer. in_ready = !rst & (!out_valid | out_ready), combinational.
//    - FULL_SKID is unreachable.
// TESTING
//  1 Reset: drive rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, out_data=0,
//    stall_cnt=0, in_ready=0.
//  2 Streaming: in_valid=1, out_ready=1, data 1,2,3,4 on consecutive cycles -> out_data
//    1,2,3,4 one cycle later, out_valid continuous, stall_cnt=0.
//  3 Stall: load data=0xA5, hold out_ready=0 for 5 cycles -> out_data=0xA5 held, stall_cnt=5.
//    No skid: in_ready=0. Skid: one more entry is accepted, then in_ready=0.
//    Release -> 0xA5, then the skid entry, in order.
//  4 Flush: FULL with ctrl=5'b11111, assert flush with in_valid=1 data=0x77 -> next cycle
//    out_valid=0, out_ctrl=0; 0x77 never appears at the output.
//  5 Saturation: STALL_CNT_W=4, stall 20 cycles -> stall_cnt=15 and held; flush does not clear it.
//  6 Reset mid-stream: rst during FULL_SKID with flush=1 -> all outputs reset values next cycle,
//    and no stale entry emerges after rst drops.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register with valid/ready handshake, stall, flush and a
// saturating stall counter. Define SKID_BUF_EN to add a 1-entry skid buffer with registered in_ready.
module pipe_stage_reg #(
  parameter int CTRL_W      = 5,
  parameter int DATA_W      = 141,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_data,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    FULL      = 2'd1,
    FULL_SKID = 2'd2
  } state_t;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + STALL_CNT_W'(1);
  endfunction

  state_t                   state;
  state_t                   state_nxt;
  logic                     vld_p1;
  logic [CTRL_W-1:0]        ctrl_p1;
  logic [DATA_W-1:0]        data_p1;
  logic [STALL_CNT_W-1:0]   stall_cnt_p1;
  logic                     in_fire;
  logic                     out_fire;
  logic                     load_in;

  assign vld_p1   = (state != EMPTY);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = vld_p1 & out_ready;

`ifdef SKID_BUF_EN
  logic                     load_skid;
  logic                     fill_skid;
  logic                     ready_p1;
  logic [CTRL_W-1:0]        skid_ctrl_p1;
  logic [DATA_W-1:0]        skid_data_p1;

  // in_ready depends only on registered state (and the reset input), never on out_ready
  assign in_ready = ready_p1 & ~rst;
`else
  assign in_ready = ~rst & (~vld_p1 | out_ready);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_in   = 1'b0;
`ifdef SKID_BUF_EN
    load_skid = 1'b0;
    fill_skid = 1'b0;
`endif
    if (flush) begin
      // An entry accepted this cycle is consumed and dropped
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = FULL;
            load_in   = 1'b1;
          end
        end
        FULL: begin
          if (out_fire) begin
            if (in_fire) load_in   = 1'b1;
            else         state_nxt = EMPTY;
          end
`ifdef SKID_BUF_EN
          else if (in_fire) begin
            state_nxt = FULL_SKID;
            fill_skid = 1'b1;
          end
`endif
        end
        FULL_SKID: begin
`ifdef SKID_BUF_EN
          if (out_fire) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end
`else
          state_nxt = EMPTY;
`endif
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Stage boundary p1: output entry; ctrl forced to zero whenever the stage goes empty
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_p1 <= '0;
      data_p1 <= '0;
    end else if (load_in) begin
      ctrl_p1 <= in_ctrl;
      data_p1 <= in_data;
    end
`ifdef SKID_BUF_EN
    else if (load_skid) begin
      ctrl_p1 <= skid_ctrl_p1;
      data_p1 <= skid_data_p1;
    end
`endif
    else if (state_nxt == EMPTY) begin
      ctrl_p1 <= '0;
    end
  end

`ifdef SKID_BUF_EN
  // Stage boundary p1 (skid): holds the entry accepted while the output was stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_ctrl_p1 <= '0;
      skid_data_p1 <= '0;
      ready_p1     <= 1'b1;
    end else begin
      if (fill_skid) begin
        skid_ctrl_p1 <= in_ctrl;
        skid_data_p1 <= in_data;
      end
      ready_p1 <= (state_nxt != FULL_SKID);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst)                   stall_cnt_p1 <= '0;
    else if (vld_p1 & ~out_ready) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
  end

  assign out_valid = vld_p1;
  assign out_ctrl  = ctrl_p1;
  assign out_data  = data_p1;
  assign stall_cnt = stall_cnt_p1;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: vector table, directed stall/flush/saturation/reset sequences,
// and randomized traffic checked against a queue-based model of the stage.
module tb_pipe_stage_reg;

  localparam int CTRL_W = 5;
  localparam int W      = 141;
  localparam int CNT_W  = 4;
  localparam int MAXC   = (1 << CNT_W) - 1;
`ifdef SKID_BUF_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [W-1:0]      in_data, out_data;
  logic [CNT_W-1:0]  stall_cnt;

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(W), .STALL_CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the stage is a FIFO of capacity 1 (2 with skid)
  typedef struct {
    logic [CTRL_W-1:0] c;
    logic [W-1:0]      d;
  } ent_t;
  ent_t         mq[$];
  int           m_cnt = 0;
  logic [W-1:0] m_data = '0;
  logic         m_rdy;
  logic         rdy_seen;
  bit           check_model = 1'b0;

  function automatic logic model_ready();
    if (rst) return 1'b0;
    if (SKID) return mq.size() < 2;
    return (mq.size() == 0) || out_ready;
  endfunction

  task automatic model_update(input logic r);
    ent_t e;
    if (rst) begin
      mq.delete();
      m_cnt  = 0;
      m_data = '0;
    end else begin
      if (mq.size() > 0 && !out_ready && m_cnt < MAXC) m_cnt++;
      if (flush) mq.delete();
      else begin
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        if (in_valid && r) begin
          e.c = in_ctrl;
          e.d = in_data;
          mq.push_back(e);
        end
      end
      if (mq.size() > 0) m_data = mq[0].d;
    end
  endtask

  task automatic step();
    @(negedge clk);
    m_rdy    = model_ready();
    rdy_seen = in_ready;
    if (check_model) chk("model_in_ready", W'(in_ready), W'(m_rdy));
    @(posedge clk);
    model_update(m_rdy);
    #1;
    if (check_model) begin
      chk("model_out_valid", W'(out_valid), W'(mq.size() > 0));
      chk("model_out_ctrl", W'(out_ctrl), (mq.size() > 0) ? W'(mq[0].c) : '0);
      chk("model_out_data", out_data, m_data);
      chk("model_stall_cnt", W'(stall_cnt), W'(m_cnt));
    end
  endtask

  task automatic set_in(input logic r, input logic f, input logic v, input int c,
                        input logic [W-1:0] d, input logic o);
    rst       = r;
    flush     = f;
    in_valid  = v;
    in_ctrl   = CTRL_W'(c);
    in_data   = d;
    out_ready = o;
  endtask

  task automatic do_reset();
    set_in(1'b1, 1'b0, 1'b0, 0, '0, 1'b1);
    step();
  endtask

  typedef struct {
    logic r, f, v, o;
    int   c;
    int   d;
    logic e_rdy, e_v;
    int   e_c, e_d, e_cnt;
  } vec_t;

  function automatic vec_t mk(logic r, logic f, logic v, int c, int d, logic o,
                              logic er, logic ev, int ec, int ed, int ecnt);
    vec_t t;
    t.r = r; t.f = f; t.v = v; t.c = c; t.d = d; t.o = o;
    t.e_rdy = er; t.e_v = ev; t.e_c = ec; t.e_d = ed; t.e_cnt = ecnt;
    return t;
  endfunction

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [159:0] r160;
    //           rst flush vin ctrl  data  ordy | rdy   vld ctrl  data  cnt
    tbl[0] = mk(1, 0, 1, 3,    9,    1,  0,    0, 0,    0,    0);
    tbl[1] = mk(1, 0, 1, 3,    9,    1,  0,    0, 0,    0,    0);
    tbl[2] = mk(0, 0, 1, 1,    1,    1,  1,    1, 1,    1,    0);
    tbl[3] = mk(0, 0, 1, 2,    2,    1,  1,    1, 2,    2,    0);
    tbl[4] = mk(0, 0, 1, 3,    3,    1,  1,    1, 3,    3,    0);
    tbl[5] = mk(0, 0, 1, 4,    4,    1,  1,    1, 4,    4,    0);
    tbl[6] = mk(0, 0, 0, 0,    0,    1,  1,    0, 0,    4,    0);
    tbl[7] = mk(0, 0, 1, 31,   'h55, 0,  1,    1, 31,   'h55, 0);
    tbl[8] = mk(0, 1, 1, 2,    'h77, 0,  SKID, 0, 0,    'h55, 1);
    tbl[9] = mk(0, 0, 0, 0,    0,    1,  1,    0, 0,    'h55, 1);

    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].c, W'(tbl[i].d), tbl[i].o);
      step();
      chk($sformatf("tbl%0d_in_ready", i), W'(rdy_seen), W'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_out_valid", i), W'(out_valid), W'(tbl[i].e_v));
      chk($sformatf("tbl%0d_out_ctrl", i), W'(out_ctrl), W'(tbl[i].e_c));
      chk($sformatf("tbl%0d_out_data", i), out_data, W'(tbl[i].e_d));
      chk($sformatf("tbl%0d_stall_cnt", i), W'(stall_cnt), W'(tbl[i].e_cnt));
    end

    // Stall with back-pressure, then release in order
    do_reset();
    set_in(1'b0, 1'b0, 1'b1, 1, W'('hA5), 1'b0);
    step();
    chk("stall_load_valid", W'(out_valid), W'(1));
    chk("stall_load_data", out_data, W'('hA5));
    for (int k = 1; k <= 5; k++) begin
      set_in(1'b0, 1'b0, 1'b1, 2, W'('hB6), 1'b0);
      step();
      chk($sformatf("stall%0d_in_ready", k), W'(rdy_seen), W'(SKID && k == 1));
      chk($sformatf("stall%0d_data", k), out_data, W'('hA5));
      chk($sformatf("stall%0d_cnt", k), W'(stall_cnt), W'(k));
    end
    set_in(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
    step();
    chk("release1_valid", W'(out_valid), W'(SKID));
    chk("release1_data", out_data, SKID ? W'('hB6) : W'('hA5));
    chk("release1_cnt", W'(stall_cnt), W'(5));
    step();
    chk("release2_valid", W'(out_valid), W'(0));
    chk("release2_ctrl", W'(out_ctrl), W'(0));

    // Saturating stall counter; flush leaves it alone
    do_reset();
    set_in(1'b0, 1'b0, 1'b1, 3, W'('hC3), 1'b0);
    step();
    for (int k = 1; k <= 20; k++) begin
      set_in(1'b0, 1'b0, 1'b0, 0, '0, 1'b0);
      step();
      chk($sformatf("sat%0d_cnt", k), W'(stall_cnt), W'((k < MAXC) ? k : MAXC));
    end
    set_in(1'b0, 1'b1, 1'b0, 0, '0, 1'b0);
    step();
    chk("sat_flush_valid", W'(out_valid), W'(0));
    chk("sat_flush_cnt", W'(stall_cnt), W'(MAXC));
    set_in(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
    step();
    chk("sat_idle_cnt", W'(stall_cnt), W'(MAXC));

    // Reset while full (skid occupied when present) together with flush
    do_reset();
    set_in(1'b0, 1'b0, 1'b1, 1, W'('hD1), 1'b0);
    step();
    set_in(1'b0, 1'b0, 1'b1, 2, W'('hD2), 1'b0);
    step();
    set_in(1'b1, 1'b1, 1'b1, 31, W'('hD3), 1'b0);
    step();
    chk("rstmid_in_ready", W'(rdy_seen), W'(0));
    chk("rstmid_valid", W'(out_valid), W'(0));
    chk("rstmid_ctrl", W'(out_ctrl), W'(0));
    chk("rstmid_data", out_data, W'(0));
    chk("rstmid_cnt", W'(stall_cnt), W'(0));
    for (int k = 0; k < 3; k++) begin
      set_in(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
      step();
      chk($sformatf("rstmid_after%0d_valid", k), W'(out_valid), W'(0));
      chk($sformatf("rstmid_after%0d_data", k), out_data, W'(0));
    end

    // Randomized traffic against the model
    do_reset();
    check_model = 1'b1;
    for (int n = 0; n < 600; n++) begin
      r160 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      set_in($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
             $urandom_range(0, 3) != 0, int'($urandom_range(0, 31)), r160[W-1:0],
             $urandom_range(0, 2) != 0);
      step();
    end
    check_model = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
